// File: rtl/hybrid_mem_arbiter_pkg.sv
// Shared types and constants for the hybrid cache memory arbiter.
package hybrid_cache_pkg;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, DONE} state_e;
  typedef enum logic {DCACHE = 1'b0, ICACHE = 1'b1} owner_e;

  localparam int unsigned DEF_DATABITS   = 32;
  localparam int unsigned DEF_BURSTBITS  = 2;
  localparam int unsigned LINE_WORDS     = 2**DEF_BURSTBITS;
  localparam int unsigned BYTES_PER_WORD = DEF_DATABITS/8;

  function automatic owner_e other_owner(input owner_e o);
    return (o == DCACHE) ? ICACHE : DCACHE;
  endfunction

endpackage

// File: rtl/hybrid_mem_arbiter_if.sv
// Bundle of cache-engine and memory-side signals; master = the arbiter.
interface hybrid_mem_arbiter_if #(
  parameter int unsigned ADDRBITS  = 32,
  parameter int unsigned DATABITS  = 32,
  parameter int unsigned BURSTBITS = 2
);
  logic [ADDRBITS-1:0]  d_addr;
  logic                 d_rd;
  logic                 d_wr;
  logic [DATABITS-1:0]  d_wdata;
  logic                 d_grant;
  logic [BURSTBITS-1:0] d_beat;
  logic [DATABITS-1:0]  d_rdata;
  logic                 d_rdata_valid;
  logic                 d_done;

  logic [ADDRBITS-1:0]  i_addr;
  logic                 i_rd;
  logic                 i_grant;
  logic [BURSTBITS-1:0] i_beat;
  logic [DATABITS-1:0]  i_rdata;
  logic                 i_rdata_valid;
  logic                 i_done;

  logic [ADDRBITS-1:0]  mem_addr;
  logic [DATABITS-1:0]  mem_in;
  logic [DATABITS-1:0]  mem_out;
  logic                 mem_out_valid;
  logic                 mem_wrreq;
  logic                 mem_rdreq;

  modport master (
    input  d_addr, d_rd, d_wr, d_wdata, i_addr, i_rd, mem_out, mem_out_valid,
    output d_grant, d_beat, d_rdata, d_rdata_valid, d_done,
           i_grant, i_beat, i_rdata, i_rdata_valid, i_done,
           mem_addr, mem_in, mem_wrreq, mem_rdreq
  );

  modport slave (
    output d_addr, d_rd, d_wr, d_wdata, i_addr, i_rd, mem_out, mem_out_valid,
    input  d_grant, d_beat, d_rdata, d_rdata_valid, d_done,
           i_grant, i_beat, i_rdata, i_rdata_valid, i_done,
           mem_addr, mem_in, mem_wrreq, mem_rdreq
  );
endinterface

// File: rtl/hybrid_mem_arbiter_rr_arb2.sv
// Two-way combinational picker; ties go to the client that was not last owner.
// HYBRID_ARB_DCACHE_PRIO_EN: ties always go to the dcache instead.
module rr_arb2
  import hybrid_cache_pkg::*;
(
  input  logic   req_dc_i,
  input  logic   req_ic_i,
  input  owner_e last_owner_i,
  output owner_e winner_o,
  output logic   valid_o
);

  always_comb begin
    valid_o  = req_dc_i | req_ic_i;
    winner_o = DCACHE;
    if (req_dc_i && req_ic_i) begin
`ifdef HYBRID_ARB_DCACHE_PRIO_EN
      winner_o = DCACHE;
`else
      winner_o = other_owner(last_owner_i);
`endif
    end else if (req_ic_i) begin
      winner_o = ICACHE;
    end
  end

`ifdef HYBRID_ARB_DCACHE_PRIO_EN
  logic unused_last;
  assign unused_last = (last_owner_i == ICACHE);
`endif

endmodule

// File: rtl/hybrid_mem_arbiter.sv
// Shares one memory port between dcache (fill/writeback) and icache (fill), one line burst per grant.
// Tie policy is selected by HYBRID_ARB_DCACHE_PRIO_EN (see rr_arb2).
module hybrid_mem_arbiter
  import hybrid_cache_pkg::*;
#(
  parameter int unsigned ADDRBITS  = 32,
  parameter int unsigned DATABITS  = 32,
  parameter int unsigned BURSTBITS = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  hybrid_mem_arbiter_if.master bus
);

  localparam int unsigned          BPW       = DATABITS/8;
  localparam logic [BURSTBITS-1:0] LAST_BEAT = '1;
  localparam logic [ADDRBITS-1:0]  LINE_MASK =
    {{(ADDRBITS-BURSTBITS-2){1'b1}}, {(BURSTBITS+2){1'b0}}};

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  owner_e               last_q, last_d;
  owner_e               winner;
  logic                 arb_valid;
  logic                 wr_q, wr_d;
  logic [ADDRBITS-1:0]  base_q, base_d;
  logic [BURSTBITS-1:0] beat_q, beat_d;
  logic                 active, d_own, rvalid;

  rr_arb2 u_arb (
    .req_dc_i    (bus.d_rd | bus.d_wr),
    .req_ic_i    (bus.i_rd),
    .last_owner_i(last_q),
    .winner_o    (winner),
    .valid_o     (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    base_d  = base_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: if (arb_valid) begin
        owner_d = winner;
        wr_d    = (winner == DCACHE) && bus.d_wr;
        base_d  = ((winner == DCACHE) ? bus.d_addr : bus.i_addr) & LINE_MASK;
        beat_d  = '0;
        state_d = wr_d ? WR : RD_ISSUE;
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: if (bus.mem_out_valid) begin
        beat_d  = beat_q + BURSTBITS'(1);
        state_d = (beat_q == LAST_BEAT) ? DONE : RD_ISSUE;
      end
      WR: begin
        beat_d = beat_q + BURSTBITS'(1);
        if (beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= DCACHE;
      last_q  <= ICACHE;
      wr_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
    end
  end

  // Outputs decode from registered state only, so reset clears them at the same edge.
  assign active = (state_q == RD_ISSUE) || (state_q == RD_WAIT) || (state_q == WR);
  assign d_own  = (owner_q == DCACHE);
  assign rvalid = (state_q == RD_WAIT) && bus.mem_out_valid;

  assign bus.d_grant       = active && d_own;
  assign bus.i_grant       = active && !d_own;
  assign bus.d_beat        = beat_q;
  assign bus.i_beat        = beat_q;
  assign bus.d_rdata       = bus.mem_out;
  assign bus.i_rdata       = bus.mem_out;
  assign bus.d_rdata_valid = rvalid && d_own;
  assign bus.i_rdata_valid = rvalid && !d_own;
  assign bus.d_done        = (state_q == DONE) && d_own;
  assign bus.i_done        = (state_q == DONE) && !d_own;

  assign bus.mem_addr  = active ? base_q + ADDRBITS'(beat_q) * ADDRBITS'(BPW) : '0;
  assign bus.mem_in    = (state_q == WR) ? bus.d_wdata : '0;
  assign bus.mem_wrreq = (state_q == WR);
  assign bus.mem_rdreq = (state_q == RD_ISSUE);

endmodule

// File: tb/tb_hybrid_mem_arbiter.sv
// Scoreboard bench: transaction-level arbitration model predicts beat/done events; monitor pops and compares.
module tb_hybrid_mem_arbiter;
  import hybrid_cache_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BB = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hybrid_mem_arbiter_if #(.ADDRBITS(AW), .DATABITS(DW), .BURSTBITS(BB)) bus ();

  hybrid_mem_arbiter #(.ADDRBITS(AW), .DATABITS(DW), .BURSTBITS(BB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [31:0] wbase = 32'h0;
  assign bus.d_wdata = wbase + 32'(bus.d_beat);

  typedef struct {
    int          kind;   // 0 write beat, 1 read beat, 2 done
    int          owner;  // 0 dcache, 1 icache
    int          beat;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  gnt;    // {d_grant, i_grant}
  } ev_t;

  ev_t expq[$];
  int  tests = 0;
  int  fails = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0FFF_0000;
  endfunction

  // Memory model: 0..3 stall cycles before each read word.
  logic [31:0] rd_addr_seen = 32'h0;
  int          rwait = 0;
  bit          rpend = 1'b0;
  always @(negedge clk) begin
    bus.mem_out_valid = 1'b0;
    if (bus.mem_rdreq) begin
      rd_addr_seen = bus.mem_addr;
      rwait = $urandom_range(0, 3);
      rpend = 1'b1;
    end else if (rpend) begin
      if (rwait == 0) begin
        bus.mem_out_valid = 1'b1;
        bus.mem_out = mem_fn(rd_addr_seen);
        rpend = 1'b0;
      end else begin
        rwait--;
      end
    end
  end

  task automatic check_ev(input ev_t o);
    ev_t e;
    tests++;
    if (expq.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event kind=%0d owner=%0d beat=%0d addr=%h data=%h gnt=%b (none expected)",
               o.kind, o.owner, o.beat, o.addr, o.data, o.gnt);
    end else begin
      e = expq.pop_front();
      if (o.kind != e.kind || o.owner != e.owner || o.beat != e.beat ||
          o.addr != e.addr || o.data != e.data || o.gnt != e.gnt) begin
        fails++;
        $display("FAIL event got kind=%0d owner=%0d beat=%0d addr=%h data=%h gnt=%b expected kind=%0d owner=%0d beat=%0d addr=%h data=%h gnt=%b",
                 o.kind, o.owner, o.beat, o.addr, o.data, o.gnt,
                 e.kind, e.owner, e.beat, e.addr, e.data, e.gnt);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] g;
    #3;
    g = {bus.d_grant, bus.i_grant};
    tests++;
    if ((bus.mem_rdreq && bus.mem_wrreq) || g == 2'b11 ||
        ((bus.mem_rdreq || bus.mem_wrreq) && g == 2'b00)) begin
      fails++;
      $display("FAIL strobe_rule got rdreq=%b wrreq=%b gnt=%b expected exclusive strobes within one grant",
               bus.mem_rdreq, bus.mem_wrreq, g);
    end
    if (bus.mem_wrreq)
      check_ev('{0, 0, int'(bus.d_beat), bus.mem_addr, bus.mem_in, g});
    if (bus.d_rdata_valid)
      check_ev('{1, 0, int'(bus.d_beat), rd_addr_seen, bus.d_rdata, g});
    if (bus.i_rdata_valid)
      check_ev('{1, 1, int'(bus.i_beat), rd_addr_seen, bus.i_rdata, g});
    if (bus.d_done)
      check_ev('{2, 0, int'(bus.d_beat), 32'h0, 32'h0, g});
    if (bus.i_done)
      check_ev('{2, 1, int'(bus.i_beat), 32'h0, 32'h0, g});
  end

  int last_o = 1;  // icache, so the first tie goes to the dcache
  bit abort = 1'b0;

  task automatic sample();
    @(negedge clk);
    #3;
  endtask

  task automatic push_txn(input int owner, input bit wr, input logic [31:0] addr);
    logic [31:0] base, a;
    base = addr & ~((32'd1 << (BB + 2)) - 32'd1);
    for (int b = 0; b < int'(LINE_WORDS); b++) begin
      a = base + 32'(b * int'(BYTES_PER_WORD));
      if (wr) expq.push_back('{0, 0, b, a, wbase + 32'(b), 2'b10});
      else    expq.push_back('{1, owner, b, a, mem_fn(a), (owner == 0) ? 2'b10 : 2'b01});
    end
    expq.push_back('{2, owner, 0, 32'h0, 32'h0, 2'b00});
  endtask

  task automatic run_round(input bit allow_new, output bit busy);
    bit rd, ri, wr, got;
    int w, op;
    busy = 1'b0;
    if (abort) return;
    if (allow_new) begin
      if (!bus.d_rd && !bus.d_wr && $urandom_range(0, 2) != 0) begin
        op = $urandom_range(0, 2);
        bus.d_rd = (op != 1);
        bus.d_wr = (op != 0);
        bus.d_addr = $urandom;
        wbase = $urandom;
      end
      if (!bus.i_rd && $urandom_range(0, 2) != 0) begin
        bus.i_rd = 1'b1;
        bus.i_addr = $urandom;
      end
      if (!bus.d_rd && !bus.d_wr && !bus.i_rd) begin
        bus.d_rd = 1'b1;
        bus.d_addr = $urandom;
      end
    end
    rd = bus.d_rd || bus.d_wr;
    ri = bus.i_rd;
    if (!rd && !ri) return;
    busy = 1'b1;
`ifdef HYBRID_ARB_DCACHE_PRIO_EN
    w = rd ? 0 : 1;
`else
    w = (rd && ri) ? ((last_o == 1) ? 0 : 1) : (rd ? 0 : 1);
`endif
    wr = (w == 0) && bus.d_wr;
    push_txn(w, wr, (w == 0) ? bus.d_addr : bus.i_addr);
    last_o = w;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      sample();
      got = bus.d_done || bus.i_done;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout got no done within 200 cycles expected owner=%0d", w);
      abort = 1'b1;
      return;
    end
    if (w == 1)  bus.i_rd = 1'b0;
    else if (wr) bus.d_wr = 1'b0;
    else         bus.d_rd = 1'b0;
  endtask

  initial begin
    bit busy, seen;
    bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.i_rd = 1'b0;
    bus.d_addr = '0; bus.i_addr = '0;
    reset_n = 1'b0;
    repeat (3) sample();
    tests++;
    if ({bus.d_grant, bus.i_grant, bus.d_rdata_valid, bus.i_rdata_valid, bus.d_done, bus.i_done,
         bus.mem_rdreq, bus.mem_wrreq, bus.d_beat, bus.i_beat, bus.mem_addr, bus.mem_in} != '0) begin
      fails++;
      $display("FAIL reset_outputs got gnt=%b%b done=%b%b rd/wr=%b%b beats=%0d/%0d addr=%h in=%h expected all zero",
               bus.d_grant, bus.i_grant, bus.d_done, bus.i_done, bus.mem_rdreq, bus.mem_wrreq,
               bus.d_beat, bus.i_beat, bus.mem_addr, bus.mem_in);
    end
    reset_n = 1'b1;

    // Directed: unaligned fill, writeback, simultaneous d/i fill, d_rd+d_wr together.
    bus.d_rd = 1'b1; bus.d_addr = 32'h8000_0004;
    run_round(1'b0, busy);
    bus.d_wr = 1'b1; bus.d_addr = 32'h0000_0100; wbase = 32'h100;
    run_round(1'b0, busy);
    bus.d_rd = 1'b1; bus.d_addr = 32'h4000_0020; bus.i_rd = 1'b1; bus.i_addr = 32'h8000_0000;
    run_round(1'b0, busy);
    run_round(1'b0, busy);
    bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h0000_2000; wbase = 32'h5000;
    bus.i_rd = 1'b1; bus.i_addr = 32'h0000_3000;
    for (int k = 0; k < 3; k++) run_round(1'b0, busy);

    for (int r = 0; r < 60; r++) run_round(1'b1, busy);
    for (int r = 0; r < 4; r++) run_round(1'b0, busy);

    // Reset during beat 1 of a writeback aborts it without a done pulse.
    if (!abort) begin
      bus.d_wr = 1'b1; bus.d_addr = 32'h0000_0100; wbase = 32'h100;
      expq.push_back('{0, 0, 0, 32'h100, 32'h100, 2'b10});
      expq.push_back('{0, 0, 1, 32'h104, 32'h101, 2'b10});
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        sample();
        seen = bus.mem_wrreq && (bus.d_beat == 1);
      end
      tests++;
      if (!seen) begin
        fails++;
        $display("FAIL abort_setup got no write beat 1 expected one within 20 cycles");
      end
      reset_n = 1'b0;
      bus.d_wr = 1'b0;
      sample();
      tests++;
      if (bus.mem_wrreq || bus.d_grant || bus.d_done || bus.d_beat != 0) begin
        fails++;
        $display("FAIL reset_abort got wrreq=%b grant=%b done=%b beat=%0d expected 0 0 0 0",
                 bus.mem_wrreq, bus.d_grant, bus.d_done, bus.d_beat);
      end
      reset_n = 1'b1;
      last_o = 1;
      bus.d_wr = 1'b1; bus.d_addr = 32'h0000_0200; wbase = 32'h200;
      run_round(1'b0, busy);
    end

    repeat (3) sample();
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d events outstanding expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hybrid_mem_arbiter.md
Name: hybrid_mem_arbiter

Overview:
Shares the single word-wide memory port of the hybrid cache between the dcache engine (line fill and writeback) and the icache engine (line fill only). Each grant runs one whole-line burst of 2**BURSTBITS words, with address sequencing and beat counting done inside this block. It sits between the two cache engines of hybrid_cache and the memory interface (mem_addr/mem_in/mem_out/mem_out_valid/mem_wrreq/mem_rdreq).

Parameters:
ADDRBITS, 32, byte address width
DATABITS, 32, word width; the address step per beat is DATABITS/8
BURSTBITS, 2, log2 of words per line (4 words = 16 bytes)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
d_addr  in  ADDRBITS  dcache line address; low BURSTBITS+2 bits ignored
d_rd  in  1  dcache fill request (level)
d_wr  in  1  dcache writeback request (level)
d_wdata  in  DATABITS  writeback word for beat d_beat, driven combinationally by the client
d_grant  out  1  dcache owns the port
d_beat  out  BURSTBITS  current beat index
d_rdata  out  DATABITS  fill word
d_rdata_valid  out  1  d_rdata valid, beat d_beat
d_done  out  1  one-cycle pulse at the end of the burst
i_addr  in  ADDRBITS  icache line address
i_rd  in  1  icache fill request (level)
i_grant, i_beat, i_rdata, i_rdata_valid, i_done  out  same widths and meaning as the d_ ports
mem_addr  out  ADDRBITS  memory byte address
mem_in  out  DATABITS  write data to memory
mem_out  in  DATABITS  read data from memory
mem_out_valid  in  1  read data qualifier
mem_wrreq  out  1  write strobe
mem_rdreq  out  1  read strobe

Behaviour:
- Reset (sampled on a clk edge with reset_n=0):
  - state=IDLE; all grant/valid/done/rdreq/wrreq outputs = 0; beats = 0; mem_addr = 0; mem_in = 0.
  - last_owner = ICACHE, so the first tie goes to the dcache.
  - Reset mid-burst aborts the burst: no done pulse, strobes low after that edge.
- States: IDLE, RD_ISSUE, RD_WAIT, WR, DONE.
- IDLE arbitration, round-robin over pending requests {d_rd|d_wr, i_rd}:
  - A sole requester wins.
  - On a tie, the client that is not last_owner wins.
  - The winner is latched with the base address (addr with low BURSTBITS+2 bits cleared) and op. d_wr takes precedence over d_rd when both are set.
  - The grant output rises on the edge leaving IDLE.
- Address per beat = base + beat*(DATABITS/8). It never crosses the line.
- Read beat:
  - RD_ISSUE (1 cycle): mem_rdreq=1, mem_addr valid.
  - RD_WAIT: mem_rdreq=0. The block samples mem_out_valid and stays in RD_WAIT while it is 0.
  - When it is 1: x_rdata=mem_out and x_rdata_valid=1 for exactly one cycle. Then beat+1 and back to RD_ISSUE, or to DONE after the last beat.
  - Cost: 2 cycles per word minimum.
- Write burst (dcache only):
  - WR: mem_wrreq=1 every cycle, mem_in=d_wdata, beat increments each cycle.
  - Cost: 2**BURSTBITS cycles, then DONE.
- DONE (1 cycle):
  - x_done=1, grant drops, last_owner=owner, then IDLE.
  - A request still high in the cycle after done is a new transaction.
- mem_rdreq and mem_wrreq are never asserted together. Neither is asserted outside a grant.
- Requests deasserted mid-burst are ignored; the burst completes.
- Beat counter wraps from 2**BURSTBITS-1 to 0 at DONE.

Optional Feature:
Macro HYBRID_ARB_DCACHE_PRIO_EN:
- Defined: fixed priority; the dcache always wins ties and last_owner is unused.
- Undefined: round-robin as above.

Decomposition:
- Package hybrid_cache_pkg:
  - state enum (IDLE, RD_ISSUE, RD_WAIT, WR, DONE);
  - owner encoding (DCACHE=0, ICACHE=1);
  - LINE_WORDS = 2**BURSTBITS;
  - BYTES_PER_WORD = DATABITS/8.
- One natural sub-module, rr_arb2: a 2-input round-robin picker. Inputs: the two requests and last_owner. Outputs: winner and a valid flag. Combinational pick; the caller holds the last_owner register.
- The FSM and beat counter stay in hybrid_mem_arbiter.

Test Plan:
1. Reset, then d_rd=1 with d_addr=32'h80000004 and memory holding 0fff0001..0fff0004 at 80000000..8000000c -> mem_addr 80000000,80000004,80000008,8000000c; d_rdata 0fff0001..0fff0004 with d_beat 0..3; d_done pulse; 8 cycles plus grant and done overhead.
2. d_wr=1, d_addr=32'h00000100, d_wdata=32'h100+d_beat -> 4 consecutive mem_wrreq cycles at 100,104,108,10c with data 100..103; mem_rdreq=0 throughout; d_done.
3. d_rd and i_rd raised in the same cycle after reset -> dcache burst first, then icache. Repeat with both held -> grants alternate d,i,d,i. With HYBRID_ARB_DCACHE_PRIO_EN -> d,d,d.
4. Icache fill at 80000000, memory drives mem_out_valid=0 for 3 cycles on beat 2 -> block holds RD_WAIT; i_rdata_valid appears only when valid=1; 4 valid beats total; i_done once.
5. reset_n=0 for one cycle during beat 1 of a dcache write -> mem_wrreq=0 the next cycle; no d_done; the next request restarts at beat 0.
6. d_rd and d_wr both high -> writeback burst first; the fill is served as a later transaction after any pending icache request.
